mul_seq_param: RTL and testbench

- Parametrised iterative shift-add multiplier; successor to the fixed 32x32 sequential multiplier.
- Adds configurable operand width, per-operation signed/unsigned mode, explicit busy/done handshake and an optional zero-operand fast path.
- Sits as a shared arithmetic unit beside datapath control.
- Trades latency for area: one partial product per clock.

---
 rtl/mul_seq_param.sv | 134 +++++++++++++
 tb/tb_mul_seq_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_param.sv
// mul_seq_param: iterative shift-add multiplier, one partial product per clock.
//   Operands are captured as magnitudes with a separate sign flag, so a single
//   unsigned datapath serves both signed and unsigned operations.
// Parameters:
//   WIDTH      operand width (>=2); the product is 2*WIDTH bits and always exact
//   EARLY_ZERO 1 = skip the iterations when either captured magnitude is zero
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active HIGH despite the name
//   start        operation request, honoured in IDLE (and on the edge leaving DONE)
//   signed_mode  1 = two's-complement operands, captured with start
//   ain, bin     multiplicand / multiplier, captured with start
//   busy         high in CALC and DONE
//   done         one-cycle pulse, yout holds the new product
//   yout         product, stable between done pulses
module mul_seq_param #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          EARLY_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     ain,
  input  logic [WIDTH-1:0]     bin,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   yout
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     yout_q, yout_d;

  logic              load;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic              neg_in;

  // |x| of the most negative value wraps to itself, which is the correct
  // unsigned magnitude 2^(WIDTH-1).
  assign a_mag  = (signed_mode && ain[WIDTH-1]) ? (~ain + WIDTH'(1)) : ain;
  assign b_mag  = (signed_mode && bin[WIDTH-1]) ? (~bin + WIDTH'(1)) : bin;
  assign neg_in = signed_mode & (ain[WIDTH-1] ^ bin[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      yout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      yout_q   <= yout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    yout_d   = yout_q;
    load     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) load = 1'b1;
      end
      // Counter runs WIDTH..1 doing one partial product per cycle; the cycle
      // with the counter at 0 applies the sign and enters DONE.
      S_CALC: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          yout_d  = neg_q ? (~acc_q + PW'(1)) : acc_q;
        end else if (EARLY_ZERO && (cnt_q == CNT_FULL) &&
                     ((mcand_q == '0) || (mplier_q == '0))) begin
          acc_d = '0;
          neg_d = 1'b0;
          cnt_d = '0;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
        end
      end
      // A held start relaunches on the edge leaving DONE, giving
      // back-to-back operations without an IDLE bubble.
      S_DONE: begin
        state_d = S_IDLE;
        if (start) load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d  = S_CALC;
      cnt_d    = CNT_FULL;
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
      neg_d    = neg_in;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign yout = yout_q;

endmodule

// File: tb/tb_mul_seq_param.sv
// Scoreboard bench for mul_seq_param: three instances (32-bit with and without
// the zero fast path sharing stimulus, plus an 8-bit instance). Expected
// product and completion cycle are queued at issue; a negedge monitor pops
// them on every done pulse and checks that yout holds between pulses.
module tb_mul_seq_param;

  typedef struct {
    logic [63:0] y;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ab, rst_c;
  logic        start_ab, sm_ab, start_c, sm_c;
  logic [31:0] a_ab, b_ab;
  logic [7:0]  a_c, b_c;
  logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [63:0] y_a, y_b;
  logic [15:0] y_c;

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        rp_ab = 1'b0, rp_c = 1'b0;
  logic        armed_ab = 1'b0, armed_c = 1'b0;
  logic [63:0] ly [3];
  exp_t        q0[$], q1[$], q2[$];

  mul_seq_param #(.WIDTH(32), .EARLY_ZERO(1'b1)) u_a (
    .clk(clk), .rst_n(rst_ab), .start(start_ab), .signed_mode(sm_ab),
    .ain(a_ab), .bin(b_ab), .busy(busy_a), .done(done_a), .yout(y_a));

  mul_seq_param #(.WIDTH(32), .EARLY_ZERO(1'b0)) u_b (
    .clk(clk), .rst_n(rst_ab), .start(start_ab), .signed_mode(sm_ab),
    .ain(a_ab), .bin(b_ab), .busy(busy_b), .done(done_b), .yout(y_b));

  mul_seq_param #(.WIDTH(8), .EARLY_ZERO(1'b1)) u_c (
    .clk(clk), .rst_n(rst_c), .start(start_c), .signed_mode(sm_c),
    .ain(a_c), .bin(b_c), .busy(busy_c), .done(done_c), .yout(y_c));

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rp_ab <= rst_ab;
    rp_c  <= rst_c;
  end

  function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [63:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      return {48'b0, 16'(sa * sb)};
    end
    return {48'b0, 16'(int'(a) * int'(b))};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon(input int i, input logic d, input logic bz, input logic [63:0] y);
    exp_t e;
    int   sz;
    case (i)
      0: sz = q0.size();
      1: sz = q1.size();
      default: sz = q2.size();
    endcase
    if (d) begin
      if (sz == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done dut%0d: got done=1 required no pending operation (cycle %0d)", i, cyc);
      end else begin
        case (i)
          0: e = q0.pop_front();
          1: e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("product dut%0d", i), y, e.y);
        chk($sformatf("done_cycle dut%0d", i), 64'(cyc), 64'(e.cyc));
        chk($sformatf("busy_in_done dut%0d", i), {63'b0, bz}, 64'd1);
        ly[i] = e.y;
      end
    end else begin
      chk($sformatf("yout_hold dut%0d", i), y, ly[i]);
    end
  endtask

  always @(negedge clk) begin
    if (rp_ab) begin
      armed_ab = 1'b1;
      ly[0] = '0;
      ly[1] = '0;
    end
    if (rp_c) begin
      armed_c = 1'b1;
      ly[2] = '0;
    end
    if (armed_ab) begin
      mon(0, done_a, busy_a, y_a);
      mon(1, done_b, busy_b, y_b);
    end
    if (armed_c) mon(2, done_c, busy_c, {48'b0, y_c});
  end

  task automatic push_ab(input logic s, input logic [31:0] a, input logic [31:0] b, input int unsigned cap);
    exp_t e;
    e.y   = ref32(s, a, b);
    e.cyc = cap + (((a == 0) || (b == 0)) ? 2 : 33);
    q0.push_back(e);
    e.cyc = cap + 33;
    q1.push_back(e);
  endtask

  task automatic wait_idle_ab();
    int k = 0;
    while ((busy_a || busy_b) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("timeout_idle_ab", 64'(busy_a | busy_b), 64'd0);
  endtask

  task automatic wait_idle_c();
    int k = 0;
    while (busy_c && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("timeout_idle_c", 64'(busy_c), 64'd0);
  endtask

  task automatic op_ab(input logic s, input logic [31:0] a, input logic [31:0] b);
    start_ab = 1'b1; sm_ab = s; a_ab = a; b_ab = b;
    push_ab(s, a, b, cyc + 1);
    @(negedge clk);
    start_ab = 1'b0; sm_ab = ~s; a_ab = $urandom; b_ab = $urandom;
    chk("busy_after_start_a", 64'(busy_a), 64'd1);
    chk("busy_after_start_b", 64'(busy_b), 64'd1);
    wait_idle_ab();
  endtask

  task automatic op_c(input logic s, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    start_c = 1'b1; sm_c = s; a_c = a; b_c = b;
    e.y   = ref8(s, a, b);
    e.cyc = cyc + 1 + (((a == 0) || (b == 0)) ? 2 : 9);
    q2.push_back(e);
    @(negedge clk);
    start_c = 1'b0; sm_c = ~s; a_c = 8'($urandom); b_c = 8'($urandom);
    chk("busy_after_start_c", 64'(busy_c), 64'd1);
    wait_idle_c();
  endtask

  // start held for 225 edges with operands changing every cycle; captures
  // land every WIDTH+2 edges and only those operands are expected.
  task automatic held_ab();
    int unsigned nxt;
    logic s;
    logic [31:0] a, b;
    nxt = cyc + 1;
    start_ab = 1'b1;
    for (int k = 0; k < 225; k++) begin
      s = 1'($urandom); a = $urandom | 32'd1; b = $urandom | 32'd1;
      sm_ab = s; a_ab = a; b_ab = b;
      if (cyc + 1 == nxt) begin
        push_ab(s, a, b, nxt);
        nxt = nxt + 34;
      end
      @(negedge clk);
    end
    start_ab = 1'b0;
    wait_idle_ab();
  endtask

  initial begin
    rst_ab = 1'b1; rst_c = 1'b1;
    start_ab = 1'b0; sm_ab = 1'b0; a_ab = '0; b_ab = '0;
    start_c = 1'b0; sm_c = 1'b0; a_c = '0; b_c = '0;
    repeat (3) @(negedge clk);
    rst_ab = 1'b0; rst_c = 1'b0;
    chk("reset_busy_a", 64'(busy_a), 64'd0);
    chk("reset_done_a", 64'(done_a), 64'd0);
    chk("reset_yout_a", y_a, 64'd0);
    chk("reset_busy_c", 64'(busy_c), 64'd0);
    chk("reset_yout_c", {48'b0, y_c}, 64'd0);

    op_ab(1'b0, 32'd89, 32'd33);
    op_ab(1'b1, 32'hFFFF_FFA7, 32'd33);
    op_ab(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op_ab(1'b1, 32'h8000_0000, 32'h8000_0000);
    op_ab(1'b1, 32'hFFFF_FFFF, 32'd1);
    op_ab(1'b1, 32'd0, 32'hFFFF_FFFB);
    op_ab(1'b0, 32'd12345, 32'd0);

    held_ab();

    // reset in the middle of CALC: pending results are discarded
    start_ab = 1'b1; sm_ab = 1'b0; a_ab = 32'd89; b_ab = 32'd33;
    @(negedge clk);
    start_ab = 1'b0;
    repeat (9) @(negedge clk);
    q0.delete();
    q1.delete();
    rst_ab = 1'b1;
    repeat (2) @(negedge clk);
    rst_ab = 1'b0;
    chk("midreset_busy_a", 64'(busy_a), 64'd0);
    chk("midreset_busy_b", 64'(busy_b), 64'd0);
    chk("midreset_yout_a", y_a, 64'd0);
    chk("midreset_done_a", 64'(done_a), 64'd0);
    op_ab(1'b0, 32'd7, 32'd6);

    for (int n = 0; n < 20; n++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      op_ab(1'($urandom), a, b);
    end

    op_c(1'b0, 8'd7, 8'd6);
    op_c(1'b1, 8'h80, 8'h80);
    op_c(1'b0, 8'hFF, 8'hFF);
    op_c(1'b1, 8'hFF, 8'h01);
    op_c(1'b1, 8'h00, 8'hFB);
    op_c(1'b1, 8'h80, 8'h7F);
    for (int n = 0; n < 25; n++) begin
      logic [7:0] a, b;
      a = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      op_c(1'($urandom), a, b);
    end

    repeat (5) @(negedge clk);
    chk("pending_dut0", 64'(q0.size()), 64'd0);
    chk("pending_dut1", 64'(q1.size()), 64'd0);
    chk("pending_dut2", 64'(q2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
